// File: rtl/rescale_controller_if.sv
// Bundles the controller's handshake, search-engine and output signals.
// master: the controller's view. slave: the surrounding source/engine/sink view.
interface rescale_controller_if #(
    parameter int unsigned NB_PIXEL = 19,
    parameter int unsigned NB_COUNT = 32,
    parameter int unsigned NB_OUT   = 8
) ();
    logic                       i_start;
    logic [NB_COUNT-1:0]        i_imageSize;
    logic                       i_pixValid;
    logic signed [NB_PIXEL-1:0] i_pixValue;
    logic                       o_pixReady;
    logic                       o_pass;
    logic                       o_searchClear;
    logic                       o_searchValid;
    logic signed [NB_PIXEL-1:0] o_searchValue;
    logic signed [NB_PIXEL-1:0] i_searchMax;
    logic signed [NB_PIXEL-1:0] i_searchMin;
    logic                       i_searchEnd;
    logic                       o_outValid;
    logic [NB_OUT-1:0]          o_outPixel;
    logic                       i_outReady;
    logic [4:0]                 o_shift;
    logic                       o_busy;
    logic                       o_done;
    logic                       o_error;

    modport master (
        input  i_start, i_imageSize, i_pixValid, i_pixValue,
        input  i_searchMax, i_searchMin, i_searchEnd, i_outReady,
        output o_pixReady, o_pass, o_searchClear, o_searchValid, o_searchValue,
        output o_outValid, o_outPixel, o_shift, o_busy, o_done, o_error
    );

    modport slave (
        output i_start, i_imageSize, i_pixValid, i_pixValue,
        output i_searchMax, i_searchMin, i_searchEnd, i_outReady,
        input  o_pixReady, o_pass, o_searchClear, o_searchValid, o_searchValue,
        input  o_outValid, o_outPixel, o_shift, o_busy, o_done, o_error
    );
endinterface

// File: rtl/rescale_controller.sv
// Two-pass frame sequencer: pass 1 feeds the extreme-search engine, pass 2 replays
// the frame and maps each value to an unsigned pixel (x - min) >> shift.
module rescale_controller #(
    parameter int unsigned NB_PIXEL = 19,
    parameter int unsigned NB_COUNT = 32,
    parameter int unsigned NB_OUT   = 8,
    parameter int unsigned TIMEOUT  = 64
) (
    input logic                  clock,
    input logic                  reset,
    rescale_controller_if.master bus
);
    localparam int unsigned MaxShift = NB_PIXEL + 1 - NB_OUT;
    localparam int unsigned TimerW   = $clog2(TIMEOUT + 1);
    localparam logic [NB_PIXEL:0] OutMax = {{(NB_PIXEL + 1 - NB_OUT){1'b0}}, {NB_OUT{1'b1}}};

    typedef enum logic [2:0] {
        StIdle, StClear, StSearch, StWaitEnd, StCalc, StRescale, StDrain, StDone
    } state_e;

    state_e state_q, state_d;

    logic [NB_COUNT-1:0]        size_q, size_d;
    logic [NB_COUNT-1:0]        count_q, count_d;
    logic signed [NB_PIXEL-1:0] min_q, min_d;
    logic [4:0]                 shift_q, shift_d;
    logic                       err_q, err_d;
    logic [TimerW-1:0]          timer_q, timer_d;
    logic                       srch_valid_q, srch_valid_d;
    logic [NB_PIXEL-1:0]        srch_value_q, srch_value_d;
    logic                       out_valid_q, out_valid_d;
    logic [NB_OUT-1:0]          out_pixel_q, out_pixel_d;

    logic                pix_ready, pass, clear, busy, done;
    logic                handshake, last_pix, timeout_hit, calc_fault;
    logic [NB_PIXEL:0]   range_w, diff, shifted;
    logic [4:0]          calc_shift;
    logic [NB_OUT-1:0]   scaled;

    assign handshake   = bus.i_pixValid & pix_ready;
    assign last_pix    = (count_q == size_q - NB_COUNT'(1));
    assign timeout_hit = (timer_q == TimerW'(TIMEOUT - 1));
    // Engine reports max below min only on a fault.
    assign calc_fault  = (bus.i_searchMax < bus.i_searchMin);

    // Range of the frame and the smallest shift that fits it into NB_OUT bits.
    always_comb begin
        range_w = {bus.i_searchMax[NB_PIXEL-1], bus.i_searchMax}
                - {bus.i_searchMin[NB_PIXEL-1], bus.i_searchMin};
        calc_shift = 5'(MaxShift);
        // Descending scan so the last hit is the smallest fitting shift.
        for (int s = int'(MaxShift); s >= 0; s--) begin
            if ((range_w >> s) <= OutMax) begin
                calc_shift = 5'(s);
            end
        end
    end

    // Map one replayed value to a clamped output pixel.
    always_comb begin
        diff    = {bus.i_pixValue[NB_PIXEL-1], bus.i_pixValue} - {min_q[NB_PIXEL-1], min_q};
        shifted = diff >> shift_q;
        if (diff[NB_PIXEL]) begin
            scaled = '0;
        end else if (shifted > OutMax) begin
            scaled = '1;
        end else begin
            scaled = shifted[NB_OUT-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_start && (bus.i_imageSize != '0)) begin
                    state_d = StClear;
                end
            end
            StClear:   state_d = StSearch;
            StSearch: begin
                if (handshake && last_pix) begin
                    state_d = StWaitEnd;
                end
            end
            StWaitEnd: begin
                if (bus.i_searchEnd) begin
                    state_d = StCalc;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StCalc:    state_d = calc_fault ? StIdle : StRescale;
            StRescale: begin
                if (handshake && last_pix) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!out_valid_q || bus.i_outReady) begin
                    state_d = StDone;
                end
            end
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM state-decoded outputs.
    always_comb begin
        pix_ready = 1'b0;
        pass      = 1'b0;
        clear     = 1'b0;
        done      = 1'b0;
        busy      = (state_q != StIdle);
        unique case (state_q)
            StClear:   clear = 1'b1;
            StSearch:  pix_ready = 1'b1;
            StRescale: begin
                pass = 1'b1;
                // Single output register: accept only if it is empty or draining now.
                pix_ready = bus.i_outReady | ~out_valid_q;
            end
            StDone:    done = 1'b1;
            default:   ;
        endcase
    end

    // Datapath next-state: counters, latched frame parameters and output registers.
    always_comb begin
        size_d       = size_q;
        count_d      = count_q;
        min_d        = min_q;
        shift_d      = shift_q;
        err_d        = err_q;
        timer_d      = timer_q;
        srch_valid_d = 1'b0;
        srch_value_d = srch_value_q;
        out_valid_d  = out_valid_q;
        out_pixel_d  = out_pixel_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    size_d  = bus.i_imageSize;
                    count_d = '0;
                    err_d   = (bus.i_imageSize == '0);
                end
            end
            StSearch: begin
                timer_d = '0;
                if (handshake) begin
                    srch_valid_d = 1'b1;
                    srch_value_d = bus.i_pixValue;
                    count_d      = count_q + NB_COUNT'(1);
                end
            end
            StWaitEnd: begin
                timer_d = timer_q + TimerW'(1);
                if (!bus.i_searchEnd && timeout_hit) begin
                    err_d = 1'b1;
                end
            end
            StCalc: begin
                min_d   = bus.i_searchMin;
                count_d = '0;
                if (calc_fault) begin
                    err_d = 1'b1;
                end else begin
                    shift_d = calc_shift;
                end
            end
            StRescale: begin
                if (handshake) begin
                    out_valid_d = 1'b1;
                    out_pixel_d = scaled;
                    count_d     = count_q + NB_COUNT'(1);
                end else if (bus.i_outReady) begin
                    out_valid_d = 1'b0;
                end
            end
            StDrain: begin
                if (bus.i_outReady) begin
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            size_q       <= '0;
            count_q      <= '0;
            min_q        <= '0;
            shift_q      <= '0;
            err_q        <= 1'b0;
            timer_q      <= '0;
            srch_valid_q <= 1'b0;
            srch_value_q <= '0;
            out_valid_q  <= 1'b0;
            out_pixel_q  <= '0;
        end else begin
            size_q       <= size_d;
            count_q      <= count_d;
            min_q        <= min_d;
            shift_q      <= shift_d;
            err_q        <= err_d;
            timer_q      <= timer_d;
            srch_valid_q <= srch_valid_d;
            srch_value_q <= srch_value_d;
            out_valid_q  <= out_valid_d;
            out_pixel_q  <= out_pixel_d;
        end
    end

    assign bus.o_pixReady    = pix_ready;
    assign bus.o_pass        = pass;
    assign bus.o_searchClear = clear;
    assign bus.o_searchValid = srch_valid_q;
    assign bus.o_searchValue = srch_value_q;
    assign bus.o_outValid    = out_valid_q;
    assign bus.o_outPixel    = out_pixel_q;
    assign bus.o_shift       = shift_q;
    assign bus.o_busy        = busy;
    assign bus.o_done        = done;
    assign bus.o_error       = err_q;
endmodule

// File: doc/rescale_controller.md
Name: rescale_controller

Overview:
- Two-pass frame sequencer for the rescaling path.
- Pass 1 streams a frame of signed convolution results into the extreme-search engine, then captures the max and min it reports.
- Pass 2 replays the same frame and maps each value to an NB_OUT-bit unsigned pixel: (x - min) >> shift, where shift is derived from the range max - min.
- Sits between the convolution output buffer (which replays the frame on request) and the display/writeback stage.

Parameters:
NB_PIXEL, 19, signed width of convolution values and of the search engine max/min.
NB_COUNT, 32, width of image size and pixel counters.
NB_OUT, 8, unsigned output pixel width.
TIMEOUT, 64, max cycles to wait for i_searchEnd after the last pass-1 pixel.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
i_start  in  1  one-cycle pulse; accepted only in IDLE.
i_imageSize  in  NB_COUNT  pixels per frame; latched on accepted i_start.
i_pixValid  in  1  source value valid.
i_pixValue  in  NB_PIXEL  signed source value.
o_pixReady  out  1  controller accepts the value this cycle.
o_pass  out  1  0 = search pass, 1 = rescale pass (source replay select).
o_searchClear  out  1  one-cycle clear pulse to the search engine.
o_searchValid  out  1  forwarded value valid to the search engine.
o_searchValue  out  NB_PIXEL  forwarded value.
i_searchMax  in  NB_PIXEL  engine maximum (signed).
i_searchMin  in  NB_PIXEL  engine minimum (signed).
i_searchEnd  in  1  engine finished.
o_outValid  out  1  output pixel valid.
o_outPixel  out  NB_OUT  rescaled pixel.
i_outReady  in  1  downstream accepts the output.
o_shift  out  5  shift in use; held until the next CALC.
o_busy  out  1  high in every state except IDLE.
o_done  out  1  one-cycle pulse at frame completion.
o_error  out  1  sticky; cleared by the next accepted i_start.

Behaviour:
- Reset (reset = 0): state IDLE. Every output is 0, including o_shift, o_error, the latched max/min and the counters.
- States and transitions:
  - IDLE: on i_start, latch i_imageSize and clear o_error. Size 0 sets o_error and stays in IDLE. Otherwise go to CLEAR.
  - CLEAR: o_searchClear = 1 for exactly 1 cycle, then SEARCH.
  - SEARCH: o_pass = 0, o_pixReady = 1. A handshake is i_pixValid & o_pixReady.
    - On each handshake, o_searchValid and o_searchValue are registered one cycle later, and the counter increments.
    - When the count reaches imageSize, go to WAIT_END.
  - WAIT_END: o_pixReady = 0. On i_searchEnd, go to CALC.
    - If TIMEOUT cycles elapse without i_searchEnd: set o_error, go to IDLE, no o_done.
  - CALC (1 cycle): latch max/min. range = max - min, computed in NB_PIXEL+1 bits, unsigned.
    - shift = smallest s in 0..NB_PIXEL+1-NB_OUT with (range >> s) <= 2^NB_OUT - 1.
    - Reset the counter, go to RESCALE.
    - max < min (engine fault) sets o_error and goes to IDLE.
  - RESCALE: o_pass = 1, o_pixReady = i_outReady | ~o_outValid (single output register).
    - Each handshake registers o_outPixel = clamp((x - min) >> shift) with o_outValid = 1. Latency is 1 cycle.
    - Clamp: x < min gives 0; a result above 2^NB_OUT - 1 gives 2^NB_OUT - 1.
    - o_outValid/o_outPixel are held stable while ~i_outReady.
    - After imageSize handshakes, go to DRAIN.
  - DRAIN: wait until the last output is accepted (o_outValid & i_outReady), then DONE.
  - DONE: o_done = 1 for 1 cycle, then IDLE.
- i_start outside IDLE is ignored.
- i_pixValid while o_pixReady = 0 is not consumed.
- range = 0 gives shift 0, and every pixel maps to 0.
- Counter compare uses the full NB_COUNT width; no wrap within a frame.
- Reset mid-frame: immediate return to IDLE with all outputs 0. Partial output is abandoned and o_done does not pulse.

Test Plan:
- Frame of 100 values 0..99 with index 3 = -1, engine returns max 99 / min -1, i_outReady = 1 -> shift 0, outputs k+1 for every k except index 3 -> 0, one o_done pulse, exactly 100 o_outValid cycles.
- Values span min 0 / max 1000 -> o_shift = 2, input 1000 -> 250, input 3 -> 0, input 999 -> 249.
- i_start with i_imageSize = 0 -> o_error = 1, o_busy stays 0, no o_searchClear.
- RESCALE with i_outReady toggling 1,0,0,1 -> o_outPixel held unchanged while stalled, o_pixReady = 0 while stalled, no pixel lost or duplicated; count of accepted outputs = imageSize.
- i_searchEnd withheld -> exactly TIMEOUT cycles after WAIT_END entry, o_error = 1, return to IDLE, no o_done.
- Assert reset = 0 midway through RESCALE of a 100-pixel frame -> all outputs 0 asynchronously. A new i_start then completes a full frame correctly.
